issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl.sv | 130 +++++++++++++
 tb/tb_issue_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// Dual-issue controller: scoreboard hazard check on the two FIFO head entries,
// pairing rules for slot 1, and a registered issue stage with stall/flush.
package issue_ctrl_pkg;
  typedef struct packed {
    logic [1:0][4:0] r_reg;
    logic [4:0]      w_reg;
  } reg_info_t;

  typedef struct packed {
    logic [31:0] payload;
    reg_info_t   register_info;
  } inst_t;

  localparam logic [1:0] CLS_ALU    = 2'b00;
  localparam logic [1:0] CLS_MUL    = 2'b01;
  localparam logic [1:0] CLS_LOAD   = 2'b10;
  localparam logic [1:0] CLS_SERIAL = 2'b11;
endpackage

module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  inst_t     [1:0] inst_i,
  input  logic      [1:0] inst_valid_i,
  input  logic [1:0][1:0] inst_class_i,
  output logic      [1:0] issue_num_o,
  output logic            backend_stall_o,
  input  logic            exec_stall_i,
  input  logic            flush_i,
  output inst_t     [1:0] issue_inst_o,
  output logic      [1:0] issue_valid_o
);

  logic [1:0]  cnt_q [32];
  logic [1:0]  cnt_d [32];
  logic [31:0] busy;
  logic [1:0]  src_haz;
  logic [1:0]  sets_cnt;
  logic [1:0][1:0] lat;
  logic        issue0;
  logic        issue1;
  logic        pair_ok;
  inst_t [1:0] issue_inst_q, issue_inst_d;
  logic  [1:0] issue_valid_q, issue_valid_d;

  // r0 is hardwired zero, so it can never be a hazard even if a count leaked in.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_r0
        assign busy[gi] = 1'b0;
      end else begin : g_rn
        assign busy[gi] = (cnt_q[gi] != 2'd0);
      end
    end

    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign src_haz[gi] =
        ((inst_i[gi].register_info.r_reg[0] != 5'd0) && busy[inst_i[gi].register_info.r_reg[0]]) ||
        ((inst_i[gi].register_info.r_reg[1] != 5'd0) && busy[inst_i[gi].register_info.r_reg[1]]);
      assign sets_cnt[gi] = (inst_i[gi].register_info.w_reg != 5'd0) &&
                            ((inst_class_i[gi] == CLS_LOAD) || (inst_class_i[gi] == CLS_MUL));
      assign lat[gi] = (inst_class_i[gi] == CLS_LOAD) ? 2'(LOAD_LAT) : 2'(MUL_LAT);
    end
  endgenerate

  always_comb begin
    pair_ok = 1'b1;
    if ((inst_i[0].register_info.w_reg != 5'd0) &&
        ((inst_i[0].register_info.w_reg == inst_i[1].register_info.r_reg[0]) ||
         (inst_i[0].register_info.w_reg == inst_i[1].register_info.r_reg[1])))
      pair_ok = 1'b0;
    if ((inst_class_i[0] == CLS_SERIAL) || (inst_class_i[1] == CLS_SERIAL))
      pair_ok = 1'b0;
    if ((inst_class_i[0] == CLS_LOAD) && (inst_class_i[1] == CLS_LOAD))
      pair_ok = 1'b0;
    if ((inst_class_i[0] == CLS_MUL) && (inst_class_i[1] == CLS_MUL))
      pair_ok = 1'b0;
  end

  assign issue0 = inst_valid_i[0] && !src_haz[0] && !exec_stall_i && !flush_i;
  assign issue1 = issue0 && inst_valid_i[1] && !src_haz[1] && pair_ok;

  assign issue_num_o     = rst ? 2'd0 : (issue1 ? 2'd2 : (issue0 ? 2'd1 : 2'd0));
  assign backend_stall_o = exec_stall_i | flush_i;

  // Slot 1 is applied after slot 0 so it wins a shared destination.
  always_comb begin
    for (int i = 0; i < 32; i++) cnt_d[i] = cnt_q[i];
    if (flush_i) begin
      for (int i = 0; i < 32; i++) cnt_d[i] = 2'd0;
    end else if (!exec_stall_i) begin
      for (int i = 0; i < 32; i++)
        if (cnt_q[i] != 2'd0) cnt_d[i] = cnt_q[i] - 2'd1;
      if (issue0 && sets_cnt[0]) cnt_d[inst_i[0].register_info.w_reg] = lat[0];
      if (issue1 && sets_cnt[1]) cnt_d[inst_i[1].register_info.w_reg] = lat[1];
    end
  end

  always_comb begin
    issue_inst_d  = issue_inst_q;
    issue_valid_d = issue_valid_q;
    if (!exec_stall_i) begin
      issue_inst_d  = inst_i;
      issue_valid_d = {issue1, issue0};
    end
    if (flush_i) issue_valid_d = 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= 2'd0;
      issue_inst_q  <= '0;
      issue_valid_q <= 2'b00;
    end else begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
      issue_inst_q  <= issue_inst_d;
      issue_valid_q <= issue_valid_d;
    end
  end

  assign issue_inst_o  = issue_inst_q;
  assign issue_valid_o = issue_valid_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: pairing rules, scoreboard latencies, stall, flush, reset.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  inst_t     [1:0] inst_i;
  logic      [1:0] inst_valid_i;
  logic [1:0][1:0] inst_class_i;
  logic      [1:0] issue_num_o;
  logic            backend_stall_o;
  logic            exec_stall_i;
  logic            flush_i;
  inst_t     [1:0] issue_inst_o;
  logic      [1:0] issue_valid_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  issue_ctrl #(.LOAD_LAT(2), .MUL_LAT(1)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .inst_class_i(inst_class_i), .issue_num_o(issue_num_o),
    .backend_stall_o(backend_stall_o), .exec_stall_i(exec_stall_i),
    .flush_i(flush_i), .issue_inst_o(issue_inst_o), .issue_valid_o(issue_valid_o)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic inst_t mk(input logic [31:0] p, input logic [4:0] r0, input logic [4:0] r1,
                               input logic [4:0] w);
    inst_t t;
    t.payload                  = p;
    t.register_info.r_reg[0]   = r0;
    t.register_info.r_reg[1]   = r1;
    t.register_info.w_reg      = w;
    return t;
  endfunction

  // Inputs change on the falling edge; checks happen 1ns later, so the
  // registered outputs then reflect the previous drv call.
  task automatic drv(input inst_t a, input inst_t b, input logic [1:0] c0, input logic [1:0] c1,
                     input logic [1:0] v, input logic st, input logic fl);
    @(negedge clk);
    inst_i[0]       = a;
    inst_i[1]       = b;
    inst_class_i[0] = c0;
    inst_class_i[1] = c1;
    inst_valid_i    = v;
    exec_stall_i    = st;
    flush_i         = fl;
    #1;
  endtask

  inst_t nop, alu4, alu5, ld6, rd6, ld7, rd7, ld9, alu15, rd9, ld20, rd20;
  inst_t ldw21, mulw21, rd21, mul22, rd22;

  initial begin
    nop = mk(32'h0, 5'd0, 5'd0, 5'd0);
    rst = 1'b1;
    inst_i = '0; inst_valid_i = 2'b00; inst_class_i = '0;
    exec_stall_i = 1'b0; flush_i = 1'b0;
    #3;
    check_val("reset_valid", 64'(issue_valid_o), 64'd0);
    check_val("reset_inst", 64'(issue_inst_o), 64'd0);
    check_val("reset_num", 64'(issue_num_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two independent ALU ops issue together.
    alu4 = mk(32'hA004, 5'd1, 5'd2, 5'd4);
    alu5 = mk(32'hA005, 5'd1, 5'd2, 5'd5);
    drv(alu4, alu5, CLS_ALU, CLS_ALU, 2'b11, 1'b0, 1'b0);
    check_val("dual_alu_num", 64'(issue_num_o), 64'd2);
    check_val("no_stall", 64'(backend_stall_o), 64'd0);
    drv(nop, nop, CLS_ALU, CLS_ALU, 2'b00, 1'b0, 1'b0);
    check_val("dual_alu_valid", 64'(issue_valid_o), 64'd3);
    check_val("dual_alu_inst0", 64'(issue_inst_o[0]), 64'(alu4));
    check_val("dual_alu_inst1", 64'(issue_inst_o[1]), 64'(alu5));
    check_val("idle_num", 64'(issue_num_o), 64'd0);

    // LOAD r6 then a reader of r6: reader waits two cycles (cnt 2 -> 1 -> 0).
    ld6 = mk(32'hB006, 5'd1, 5'd2, 5'd6);
    rd6 = mk(32'hC008, 5'd6, 5'd3, 5'd8);
    drv(ld6, rd6, CLS_LOAD, CLS_ALU, 2'b11, 1'b0, 1'b0);
    check_val("ld_raw_num", 64'(issue_num_o), 64'd1);
    drv(rd6, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("ld_valid", 64'(issue_valid_o), 64'd1);
    check_val("ld_inst0", 64'(issue_inst_o[0]), 64'(ld6));
    check_val("ld_wait1", 64'(issue_num_o), 64'd0);
    drv(rd6, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("ld_bubble_valid", 64'(issue_valid_o), 64'd0);
    check_val("ld_wait2", 64'(issue_num_o), 64'd0);
    drv(rd6, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("ld_ready", 64'(issue_num_o), 64'd1);
    drv(nop, nop, CLS_ALU, CLS_ALU, 2'b00, 1'b0, 1'b0);
    check_val("rd6_valid", 64'(issue_valid_o), 64'd1);
    check_val("rd6_inst0", 64'(issue_inst_o[0]), 64'(rd6));

    // Pairing restrictions.
    drv(mk(32'h1, 5'd1, 5'd2, 5'd0), mk(32'h2, 5'd1, 5'd2, 5'd3), CLS_SERIAL, CLS_ALU, 2'b11, 1'b0, 1'b0);
    check_val("serial_pair", 64'(issue_num_o), 64'd1);
    drv(mk(32'h3, 5'd1, 5'd2, 5'd3), mk(32'h4, 5'd1, 5'd2, 5'd0), CLS_ALU, CLS_SERIAL, 2'b11, 1'b0, 1'b0);
    check_val("serial_slot1", 64'(issue_num_o), 64'd1);
    drv(mk(32'h5, 5'd1, 5'd2, 5'd10), mk(32'h6, 5'd1, 5'd2, 5'd11), CLS_LOAD, CLS_LOAD, 2'b11, 1'b0, 1'b0);
    check_val("load_load", 64'(issue_num_o), 64'd1);
    drv(mk(32'h7, 5'd1, 5'd2, 5'd13), mk(32'h8, 5'd1, 5'd2, 5'd14), CLS_MUL, CLS_MUL, 2'b11, 1'b0, 1'b0);
    check_val("mul_mul", 64'(issue_num_o), 64'd1);
    drv(mk(32'h9, 5'd1, 5'd2, 5'd12), mk(32'hA, 5'd3, 5'd12, 5'd16), CLS_ALU, CLS_ALU, 2'b11, 1'b0, 1'b0);
    check_val("intra_raw", 64'(issue_num_o), 64'd1);
    drv(mk(32'hB, 5'd1, 5'd2, 5'd0), mk(32'hC, 5'd0, 5'd0, 5'd16), CLS_ALU, CLS_ALU, 2'b11, 1'b0, 1'b0);
    check_val("r0_no_raw", 64'(issue_num_o), 64'd2);
    drv(mk(32'hD, 5'd1, 5'd2, 5'd17), mk(32'hE, 5'd1, 5'd2, 5'd18), CLS_MUL, CLS_LOAD, 2'b11, 1'b0, 1'b0);
    check_val("mul_load", 64'(issue_num_o), 64'd2);
    drv(mk(32'hF, 5'd1, 5'd2, 5'd3), mk(32'h10, 5'd1, 5'd2, 5'd19), CLS_ALU, CLS_ALU, 2'b10, 1'b0, 1'b0);
    check_val("slot1_needs_slot0", 64'(issue_num_o), 64'd0);

    // Same destination in both slots: slot 1 (LOAD, 2) overrides slot 0 (MUL, 1).
    mulw21 = mk(32'h21, 5'd1, 5'd2, 5'd21);
    ldw21  = mk(32'h22, 5'd1, 5'd2, 5'd21);
    rd21   = mk(32'h23, 5'd21, 5'd0, 5'd3);
    drv(mulw21, ldw21, CLS_MUL, CLS_LOAD, 2'b11, 1'b0, 1'b0);
    check_val("waw_num", 64'(issue_num_o), 64'd2);
    drv(rd21, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("waw_wait1", 64'(issue_num_o), 64'd0);
    drv(rd21, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("waw_wait2", 64'(issue_num_o), 64'd0);
    drv(rd21, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("waw_ready", 64'(issue_num_o), 64'd1);

    // MUL latency 1: one blocked cycle.
    mul22 = mk(32'h24, 5'd1, 5'd2, 5'd22);
    rd22  = mk(32'h25, 5'd3, 5'd22, 5'd4);
    drv(mul22, nop, CLS_MUL, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("mul_issue", 64'(issue_num_o), 64'd1);
    drv(rd22, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("mul_wait", 64'(issue_num_o), 64'd0);
    drv(rd22, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("mul_ready", 64'(issue_num_o), 64'd1);

    // Stall freezes scoreboard and outputs.
    ld7 = mk(32'h77, 5'd1, 5'd2, 5'd7);
    rd7 = mk(32'h78, 5'd7, 5'd1, 5'd23);
    drv(ld7, nop, CLS_LOAD, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("ld7_issue", 64'(issue_num_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drv(rd7, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b1, 1'b0);
      check_val($sformatf("stall%0d_num", i), 64'(issue_num_o), 64'd0);
      check_val($sformatf("stall%0d_valid", i), 64'(issue_valid_o), 64'd1);
    end
    check_val("stall_bstall", 64'(backend_stall_o), 64'd1);
    drv(rd7, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("stall_held_inst", 64'(issue_inst_o[0]), 64'(ld7));
    check_val("stall_held_valid", 64'(issue_valid_o), 64'd1);
    check_val("resume_wait1", 64'(issue_num_o), 64'd0);
    drv(rd7, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("resume_wait2", 64'(issue_num_o), 64'd0);
    drv(rd7, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("resume_ready", 64'(issue_num_o), 64'd1);

    // Flush clears valid and scoreboard.
    ld9   = mk(32'h99, 5'd1, 5'd2, 5'd9);
    alu15 = mk(32'h9A, 5'd1, 5'd2, 5'd15);
    rd9   = mk(32'h9B, 5'd9, 5'd0, 5'd24);
    drv(ld9, alu15, CLS_LOAD, CLS_ALU, 2'b11, 1'b0, 1'b0);
    check_val("pre_flush_num", 64'(issue_num_o), 64'd2);
    drv(mk(32'h9C, 5'd1, 5'd2, 5'd24), mk(32'h9D, 5'd1, 5'd2, 5'd25), CLS_ALU, CLS_ALU, 2'b11, 1'b0, 1'b1);
    check_val("pre_flush_valid", 64'(issue_valid_o), 64'd3);
    check_val("flush_num", 64'(issue_num_o), 64'd0);
    check_val("flush_bstall", 64'(backend_stall_o), 64'd1);
    drv(rd9, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("post_flush_valid", 64'(issue_valid_o), 64'd0);
    check_val("post_flush_r9_free", 64'(issue_num_o), 64'd1);

    // Asynchronous reset mid-cycle.
    ld20 = mk(32'h200, 5'd1, 5'd2, 5'd20);
    rd20 = mk(32'h201, 5'd20, 5'd0, 5'd26);
    drv(ld20, nop, CLS_LOAD, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("ld20_issue", 64'(issue_num_o), 64'd1);
    drv(rd20, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("ld20_valid", 64'(issue_valid_o), 64'd1);
    check_val("rd20_blocked", 64'(issue_num_o), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_valid", 64'(issue_valid_o), 64'd0);
    check_val("rst_inst", 64'(issue_inst_o), 64'd0);
    check_val("rst_num", 64'(issue_num_o), 64'd0);
    inst_valid_i = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    drv(rd20, nop, CLS_ALU, CLS_ALU, 2'b01, 1'b0, 1'b0);
    check_val("post_rst_r20_free", 64'(issue_num_o), 64'd1);
    drv(nop, nop, CLS_ALU, CLS_ALU, 2'b00, 1'b0, 1'b0);
    check_val("post_rst_valid", 64'(issue_valid_o), 64'd1);
    check_val("post_rst_inst", 64'(issue_inst_o[0]), 64'(rd20));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
